// File: rtl/cbsc_mac_param_if.sv
// Start/done handshake, operand and result bundle for the CBSC multiply-accumulate unit.
interface cbsc_mac_param_if #(
  parameter int W     = 7,
  parameter int ACC_W = 8
);
  logic             start;
  logic [W-1:0]     x;
  logic [W-1:0]     w;
  logic [ACC_W-1:0] z_in;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] q;
  logic [W-1:0]     p_out;

  modport master (
    output start, x, w, z_in, mode,
    input  busy, done, q, p_out
  );

  modport slave (
    input  start, x, w, z_in, mode,
    output busy, done, q, p_out
  );
endinterface

// File: rtl/cbsc_mac_param.sv
// Counter-based stochastic multiply-accumulate: x is compared against a bit-reversed
// counter for w cycles, the ones are counted into p, then p is added per mode.
module cbsc_mac_param #(
  parameter int W     = 7,
  parameter int ACC_W = 8,
  parameter int SAT   = 1
) (
  input logic             clk,
  input logic             rst,
  cbsc_mac_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, SUM} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     x_reg, dc_reg, c_reg, pc_reg, p_reg;
  logic [ACC_W-1:0] z_reg, q_reg, q_next, addend;
  logic [1:0]       mode_reg;
  logic             done_reg;
  logic [W-1:0]     c_rev;
  logic             sn;
  logic [ACC_W:0]   sum;

  // Bit-reversed reference counter gives the low-discrepancy comparison sequence.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
      assign c_rev[gi] = c_reg[W-1-gi];
    end
  endgenerate

  assign sn = (x_reg > c_rev);

  always_comb begin
    addend = '0;
    case (mode_reg)
      2'b00:   addend = z_reg;
      2'b01:   addend = q_reg;
      default: addend = '0;
    endcase
    sum    = {1'b0, addend} + {{(ACC_W+1-W){1'b0}}, pc_reg};
    q_next = sum[ACC_W-1:0];
    if (sum[ACC_W] && (SAT != 0)) begin
      q_next = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = (bus.w != '0) ? RUN : SUM;
      RUN:  if (dc_reg == W'(1)) state_next = SUM;
      SUM:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg    <= '0;
      dc_reg   <= '0;
      c_reg    <= '0;
      pc_reg   <= '0;
      p_reg    <= '0;
      z_reg    <= '0;
      q_reg    <= '0;
      mode_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            x_reg    <= bus.x;
            dc_reg   <= bus.w;
            z_reg    <= bus.z_in;
            mode_reg <= bus.mode;
            c_reg    <= '0;
            pc_reg   <= '0;
          end
        end
        RUN: begin
          pc_reg <= pc_reg + {{(W-1){1'b0}}, sn};
          c_reg  <= c_reg + W'(1);
          dc_reg <= dc_reg - W'(1);
        end
        SUM: begin
          p_reg    <= pc_reg;
          q_reg    <= q_next;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_reg == RUN) || (state_reg == SUM);
  assign bus.done  = done_reg;
  assign bus.q     = q_reg;
  assign bus.p_out = p_reg;
endmodule
